// File: rtl/fpga_synth_led_pio.sv
// Avalon-MM output PIO for the LED bank: persistent DATA register with atomic set/clear,
// plus a retriggerable one-shot pulse mask ORed onto the output.
module fpga_synth_led_pio #(
    parameter int unsigned      WIDTH       = 10,
    parameter int unsigned      PULSE_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic [0:0] {StIdle, StActive} pulse_st_e;

    pulse_st_e          state_q;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [PULSE_W-1:0] pulse_len_q, pulse_len_d;
    logic [PULSE_W-1:0] cnt_q;
    logic [WIDTH-1:0]   mask_q;
    logic [31:0]        rdata_q, rdata_d;
    logic [15:0]        cnt16;
    logic [WIDTH-1:0]   wd_w;
    logic               wr;
    logic               trig;
    logic               unused_wd;

    assign wd_w      = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign wr        = chipselect && !write_n;
    // Zero-length or zero-data triggers are dropped without touching the engine.
    assign trig      = wr && (address == 3'd2) && (pulse_len_q != '0) && (wd_w != '0);

    if (PULSE_W >= 16) begin : g_cnt_wide
        assign cnt16 = cnt_q[15:0];
    end else begin : g_cnt_narrow
        assign cnt16 = {{(16 - PULSE_W){1'b0}}, cnt_q};
    end

    always_comb begin
        data_d      = data_q;
        pulse_len_d = pulse_len_q;
        if (wr) begin
            case (address)
                3'd0:    data_d      = wd_w;
                3'd1:    pulse_len_d = writedata[PULSE_W-1:0];
                3'd4:    data_d      = data_q | wd_w;
                3'd5:    data_d      = data_q & ~wd_w;
                default: ;
            endcase
        end
    end

    // Read mux sees only current register state, so same-cycle writes read as pre-write values.
    always_comb begin
        rdata_d = '0;
        case (address)
            3'd0:    rdata_d = 32'(data_q);
            3'd1:    rdata_d = 32'(pulse_len_q);
            3'd2:    rdata_d = 32'(mask_q);
            3'd3:    rdata_d = {cnt16, 15'b0, state_q == StActive};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= RESET_VALUE;
            pulse_len_q <= '0;
            rdata_q     <= '0;
        end else begin
            data_q      <= data_d;
            pulse_len_q <= pulse_len_d;
            rdata_q     <= rdata_d;
        end
    end

    // Pulse engine: a trigger wins over the decrement; the mask drops on the 1 -> 0 edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else if (trig) begin
            state_q <= StActive;
            cnt_q   <= pulse_len_q;
            mask_q  <= mask_q | wd_w;
        end else begin
            case (state_q)
                StIdle: ;
                StActive: begin
                    cnt_q <= cnt_q - PULSE_W'(1);
                    if (cnt_q == PULSE_W'(1)) begin
                        state_q <= StIdle;
                        mask_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign readdata = rdata_q;
    assign out_port = data_q | mask_q;

endmodule
